// File: rtl/cwe1234_pkg.sv
// Shared types for the debug-unlock controller: FSM state encoding and default key width.
package cwe1234_pkg;

    localparam int DEFAULT_KEY_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        UNLOCKED,
        LOCKOUT
    } unlock_state_t;

endpackage

// File: rtl/cwe1234_down_timer.sv
// Loadable down counter that holds at zero; one instance times both debug
// sessions and lockout periods.
module cwe1234_down_timer #(
    parameter int W = 10
) (
    input  logic         Clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/cwe1234_unlock_ctrl.sv
// Debug-unlock front end for the lockable data register: key check, timed
// session, lockout on repeated failures. UNLOCK_PERMA_LOCKOUT_EN makes lockout terminal.
module cwe1234_unlock_ctrl
    import cwe1234_pkg::*;
#(
    parameter int                 KEY_W          = DEFAULT_KEY_W,
    parameter logic [KEY_W-1:0]   UNLOCK_KEY     = 16'hA5C3,
    parameter int                 MAX_FAILS      = 3,
    parameter int                 LOCKOUT_CYCLES = 256,
    parameter int                 SESSION_CYCLES = 1024
) (
    input  logic                           Clk,
    input  logic                           reset,
    input  logic                           key_valid,
    output logic                           key_ready,
    input  logic [KEY_W-1:0]               key_data,
    input  logic                           debug_exit,
    output logic                           debug_unlocked,
    output logic                           Lock,
    output logic                           lockout,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = $clog2((LOCKOUT_CYCLES > SESSION_CYCLES) ? LOCKOUT_CYCLES : SESSION_CYCLES);
    localparam logic [FW-1:0] LAST_FAIL   = FW'(MAX_FAILS - 1);
    localparam logic [FW-1:0] SAT_FAIL    = FW'(MAX_FAILS);
    localparam logic [TW-1:0] SESSION_TOP = TW'(SESSION_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_TOP = TW'(LOCKOUT_CYCLES - 1);

    unlock_state_t   r_state;
    logic [KEY_W-1:0] r_key_q;
    logic            r_debug_unlocked;
    logic            r_lock;
    logic            r_lockout;
    logic [FW-1:0]   r_fail_cnt;

    logic            w_match;
    logic            w_load;
    logic [TW-1:0]   w_load_val;
    logic            w_dec;
    logic [TW-1:0]   w_count;
    logic            w_zero;

    assign w_match    = (r_key_q == UNLOCK_KEY);
    // Timer is (re)loaded only as CHECK resolves into a session or a lockout.
    assign w_load     = (r_state == CHECK) && (w_match || (r_fail_cnt >= LAST_FAIL));
    assign w_load_val = w_match ? SESSION_TOP : LOCKOUT_TOP;
    assign w_dec      = (r_state == UNLOCKED) || (r_state == LOCKOUT);

    cwe1234_down_timer #(.W(TW)) u_timer (
        .Clk        (Clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_key_q          <= '0;
            r_debug_unlocked <= 1'b0;
            r_lock           <= 1'b0;
            r_lockout        <= 1'b0;
            r_fail_cnt       <= '0;
        end else begin
            r_lock <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (key_valid) begin
                        r_key_q <= key_data;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_match) begin
                        r_state          <= UNLOCKED;
                        r_fail_cnt       <= '0;
                        r_debug_unlocked <= 1'b1;
                    end else if (r_fail_cnt >= LAST_FAIL) begin
                        r_state    <= LOCKOUT;
                        r_fail_cnt <= SAT_FAIL;
                        r_lockout  <= 1'b1;
                        r_lock     <= 1'b1;
                    end else begin
                        r_fail_cnt <= r_fail_cnt + 1'b1;
                        r_state    <= IDLE;
                    end
                end
                UNLOCKED: begin
                    // Early exit and expiry in the same cycle collapse into one exit.
                    if (debug_exit || w_zero) begin
                        r_state          <= IDLE;
                        r_debug_unlocked <= 1'b0;
                    end
                end
                LOCKOUT: begin
`ifdef UNLOCK_PERMA_LOCKOUT_EN
                    r_state <= LOCKOUT;
`else
                    if (w_zero) begin
                        r_state    <= IDLE;
                        r_lockout  <= 1'b0;
                        r_fail_cnt <= '0;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign key_ready      = (r_state == IDLE);
    assign debug_unlocked = r_debug_unlocked;
    assign Lock           = r_lock;
    assign lockout        = r_lockout;
    assign fail_cnt       = r_fail_cnt;

endmodule
